cluster_pwr_seq: RTL and testbench
==================================

CLUSTER_PWR_SEQ -- requirements
Module: cluster_pwr_seq

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 16: cycles the power rail settles after the switch ack (legal range 1..255).
REQ-002 SHALL provide parameter ISO_CYCLES, default 4: cycles between isolation/clamp change and reset change (legal range 1..255).
REQ-003 SHALL provide port clk_i  input  1  single clock; all logic on rising edge.
REQ-004 SHALL provide port rst_ni  input  1  reset; synchronous, active-low.
REQ-005 SHALL provide port pwr_req_i  input  1  level request, 1 = cluster on, 0 = cluster off; synchronous to clk_i.
REQ-006 SHALL provide port pwr_sw_ack_i  input  1  power-switch chain ack; already synchronized to clk_i by the caller.
REQ-007 SHALL provide port pwr_sw_en_o  output  1  power-switch enable.
REQ-008 SHALL provide port iso_en_o  output  1  clamp enable for cluster input/output level shifters; 1 = clamped.
REQ-009 SHALL provide port cluster_rst_no  output  1  cluster reset, active-low.
REQ-010 SHALL provide port pwr_on_o  output  1  cluster fully on and usable.
REQ-011 SHALL provide port busy_o  output  1  sequence in progress.

Function
REQ-012 SHALL implement a state register with states OFF, SW_ON, SETTLE, ISO_REL, ON, ISO_SET, SW_OFF, plus one down-counter of 8 bits.
REQ-013 SHALL decode all outputs from the state register only: no input-to-output combinational path.
REQ-014 SHALL drive the output values in each state as follows: OFF sw=0 iso=1 rst_n=0; SW_ON/SETTLE sw=1 iso=1 rst_n=0; ISO_REL sw=1 iso=0 rst_n=0; ON sw=1 iso=0 rst_n=1; ISO_SET sw=1 iso=1 rst_n=0; SW_OFF sw=0 iso=1 rst_n=0.
REQ-015 SHALL drive pwr_on_o=1 only in ON and busy_o=1 in every state except OFF and ON.
REQ-016 SHALL move OFF -> SW_ON on an edge where pwr_req_i=1, and stay in OFF otherwise.
REQ-017 SHALL move SW_ON -> SETTLE on an edge where pwr_sw_ack_i=1, loading the counter with SETTLE_CYCLES-1; it SHALL wait indefinitely otherwise (no timeout).
REQ-018 SHALL hold SETTLE for exactly SETTLE_CYCLES cycles; at counter==0 it SHALL move to ISO_REL, loading ISO_CYCLES-1; otherwise it SHALL decrement.
REQ-019 SHALL hold ISO_REL for exactly ISO_CYCLES cycles, then move to ON.
REQ-020 SHALL move ON -> ISO_SET on an edge where pwr_req_i=0, loading ISO_CYCLES-1, so that reset asserts with isolation on the same edge.
REQ-021 SHALL hold ISO_SET for exactly ISO_CYCLES cycles, then move to SW_OFF.
REQ-022 SHALL move SW_OFF -> OFF on an edge where pwr_sw_ack_i=0, and wait indefinitely otherwise.
REQ-023 SHALL ignore pwr_req_i in every busy state; a sequence always completes, and the request is re-sampled only in OFF or ON. An opposite request during a sequence therefore starts the reverse sequence one edge after reaching the stable state.
REQ-024 SHALL never let iso_en_o=0 coincide with pwr_sw_en_o=0, and never let cluster_rst_no=1 coincide with iso_en_o=1.
REQ-025 SHALL ignore a pwr_sw_ack_i glitch in any state other than SW_ON and SW_OFF.

Reset
REQ-026 SHALL, on any edge with rst_ni=0, force state OFF and counter 0 regardless of the current state, including mid-sequence.
REQ-027 SHALL therefore present outputs after the reset edge as pwr_sw_en_o=0, iso_en_o=1, cluster_rst_no=0, pwr_on_o=0, busy_o=0; output values before the first clock edge are undefined.
REQ-028 SHALL give reset priority over all transitions.

Verification
REQ-029 Defaults, ack tied to sw_en, pwr_req_i rises at edge E0 -> SW_ON after E0, SETTLE after E1, ISO_REL after E17, ON after E21; cluster_rst_no=1 and pwr_on_o=1 from E21.
REQ-030 From ON, pwr_req_i=0 at edge F0, ack follows sw_en with 3-cycle delay -> iso=1 and rst_n=0 after F0; sw=0 after F4; OFF (busy_o=0) after the edge where ack is seen 0 (F7).
REQ-031 Ack held 0 for 50 cycles in SW_ON -> stays in SW_ON with busy_o=1, iso_en_o=1; ack rising then gives ON exactly 20 edges after the ack-sampling edge.
REQ-032 pwr_req_i dropped in the 5th SETTLE cycle -> power-up completes to ON, then ISO_SET begins on the next edge; pwr_req_i toggling 1-0-1 in SW_OFF -> reaches OFF, then SW_ON.
REQ-033 rst_ni=0 for one edge while in ISO_REL -> next cycle sw=0, iso=1, rst_n=0, busy=0; with pwr_req_i still 1, SW_ON follows the next edge.
REQ-034 Assertion bench over random req/ack traffic with SETTLE_CYCLES=1, ISO_CYCLES=1 -> REQ-024 invariants never violated and each state dwell matches REQ-018 to REQ-021.

Source files
------------

// File: rtl/cluster_pwr_seq.sv
// Cluster power sequencer: ordered switch / settle / isolation / reset control
// for one power-gated cluster, with registered state-decoded outputs.
module cluster_pwr_seq #(
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned ISO_CYCLES    = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic pwr_req_i,
    input  logic pwr_sw_ack_i,
    output logic pwr_sw_en_o,
    output logic iso_en_o,
    output logic cluster_rst_no,
    output logic pwr_on_o,
    output logic busy_o
);

    typedef enum logic [2:0] {
        OFF,
        SW_ON,
        SETTLE,
        ISO_REL,
        ON,
        ISO_SET,
        SW_OFF
    } state_e;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] ISO_LOAD    = 8'(ISO_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sw_en_q, sw_en_d;
    logic       iso_en_q, iso_en_d;
    logic       rst_n_q, rst_n_d;
    logic       pwr_on_q, pwr_on_d;
    logic       busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            OFF: begin
                if (pwr_req_i) state_d = SW_ON;
            end
            SW_ON: begin
                if (pwr_sw_ack_i) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = ISO_REL;
                    cnt_d   = ISO_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ISO_REL: begin
                if (cnt_q == '0) state_d = ON;
                else             cnt_d   = cnt_q - 8'd1;
            end
            ON: begin
                if (!pwr_req_i) begin
                    state_d = ISO_SET;
                    cnt_d   = ISO_LOAD;
                end
            end
            ISO_SET: begin
                if (cnt_q == '0) state_d = SW_OFF;
                else             cnt_d   = cnt_q - 8'd1;
            end
            SW_OFF: begin
                if (!pwr_sw_ack_i) state_d = OFF;
            end
            default: begin
                state_d = OFF;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered alongside it,
    // so they always match state_q with no input-to-output path.
    always_comb begin
        sw_en_d  = 1'b0;
        iso_en_d = 1'b1;
        rst_n_d  = 1'b0;
        pwr_on_d = 1'b0;
        busy_d   = 1'b1;
        unique case (state_d)
            OFF:     busy_d = 1'b0;
            SW_ON,
            SETTLE:  sw_en_d = 1'b1;
            ISO_REL: begin
                sw_en_d  = 1'b1;
                iso_en_d = 1'b0;
            end
            ON: begin
                sw_en_d  = 1'b1;
                iso_en_d = 1'b0;
                rst_n_d  = 1'b1;
                pwr_on_d = 1'b1;
                busy_d   = 1'b0;
            end
            ISO_SET: sw_en_d = 1'b1;
            SW_OFF:  sw_en_d = 1'b0;
            default: busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= OFF;
            cnt_q    <= '0;
            sw_en_q  <= 1'b0;
            iso_en_q <= 1'b1;
            rst_n_q  <= 1'b0;
            pwr_on_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sw_en_q  <= sw_en_d;
            iso_en_q <= iso_en_d;
            rst_n_q  <= rst_n_d;
            pwr_on_q <= pwr_on_d;
            busy_q   <= busy_d;
        end
    end

    assign pwr_sw_en_o    = sw_en_q;
    assign iso_en_o       = iso_en_q;
    assign cluster_rst_no = rst_n_q;
    assign pwr_on_o       = pwr_on_q;
    assign busy_o         = busy_q;

endmodule

// File: tb/tb_cluster_pwr_seq.sv
// Bench for cluster_pwr_seq: directed scoreboard on a default-parameter DUT,
// plus invariant checks on a short-timing DUT under random req/ack traffic.
module tb_cluster_pwr_seq;

    // Output vectors {sw, iso, rst_n, on, busy}
    localparam logic [4:0] X_OFF     = 5'b01000;
    localparam logic [4:0] X_SW_ON   = 5'b11001;
    localparam logic [4:0] X_SETTLE  = 5'b11001;
    localparam logic [4:0] X_ISO_REL = 5'b10001;
    localparam logic [4:0] X_ON      = 5'b10110;
    localparam logic [4:0] X_ISO_SET = 5'b11001;
    localparam logic [4:0] X_SW_OFF  = 5'b01001;

    typedef struct {
        int unsigned cyc;
        logic [4:0]  val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req = 1'b0;
    logic ack_drv = 1'b0;
    logic ack;
    int unsigned ack_mode = 0;
    logic [2:0] sw_hist = '0;
    logic sw, iso, crst_n, pwr_on, busy;

    logic f_req = 1'b0, f_ack = 1'b0;
    logic f_sw, f_iso, f_rst_n, f_on, f_busy;
    int unsigned f_iso_run = 0;

    exp_t q[$];
    int unsigned cyc_count = 0;
    int checks = 0;
    int errors = 0;
    bit done = 1'b0;
    bit reported = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc_count <= cyc_count + 1;
        sw_hist   <= {sw_hist[1:0], sw};
    end

    // Mode 1: ack mirrors sw_en; mode 2: ack lags sw_en by the switch-chain delay.
    always_comb begin
        case (ack_mode)
            1:       ack = sw;
            2:       ack = sw_hist[1];
            default: ack = ack_drv;
        endcase
    end

    cluster_pwr_seq u_dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pwr_req_i     (req),
        .pwr_sw_ack_i  (ack),
        .pwr_sw_en_o   (sw),
        .iso_en_o      (iso),
        .cluster_rst_no(crst_n),
        .pwr_on_o      (pwr_on),
        .busy_o        (busy)
    );

    cluster_pwr_seq #(.SETTLE_CYCLES(1), .ISO_CYCLES(1)) u_fast (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .pwr_req_i     (f_req),
        .pwr_sw_ack_i  (f_ack),
        .pwr_sw_en_o   (f_sw),
        .iso_en_o      (f_iso),
        .cluster_rst_no(f_rst_n),
        .pwr_on_o      (f_on),
        .busy_o        (f_busy)
    );

    initial begin
        forever begin
            @(posedge clk);
            #2;
            f_req = 1'($urandom_range(0, 1));
            f_ack = 1'($urandom_range(0, 1));
        end
    end

    always @(negedge clk) begin
        if (rst_n && cyc_count >= 2) begin
            checks++;
            if ((f_iso === 1'b0 && f_sw !== 1'b1) || (f_rst_n === 1'b1 && f_iso !== 1'b0)
                || (f_on !== f_rst_n) || (f_on === 1'b1 && f_busy !== 1'b0)) begin
                errors++;
                $display("FAIL fast_invariant cyc %0d got sw=%b iso=%b rst_n=%b on=%b busy=%b",
                         cyc_count, f_sw, f_iso, f_rst_n, f_on, f_busy);
            end
            if ({f_sw, f_iso, f_rst_n} == 3'b100) begin
                f_iso_run++;
            end else begin
                if (f_iso_run != 0) begin
                    checks++;
                    if (f_iso_run != 1) begin
                        errors++;
                        $display("FAIL fast_iso_rel_dwell got %0d cycles want 1", f_iso_run);
                    end
                end
                f_iso_run = 0;
            end
        end
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].cyc == cyc_count) begin
                checks++;
                if ({sw, iso, crst_n, pwr_on, busy} !== q[i].val) begin
                    errors++;
                    $display("FAIL %s cyc %0d got %b want %b", q[i].name, cyc_count,
                             {sw, iso, crst_n, pwr_on, busy}, q[i].val);
                end
                q.delete(i);
            end else if (q[i].cyc < cyc_count) begin
                checks++;
                errors++;
                $display("FAIL %s missed cyc %0d got none want %b", q[i].name, q[i].cyc, q[i].val);
                q.delete(i);
            end
        end
        if (done && !reported) begin
            checks++;
            if (q.size() != 0) begin
                errors++;
                $display("FAIL leftover got %0d pending want 0", q.size());
            end
            reported = 1'b1;
        end
    end

    task automatic edges(input int unsigned n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Expect the given outputs after the n-th upcoming edge (0 = the edge just passed).
    task automatic expect_after(input int unsigned n, input logic [4:0] v, input string name);
        exp_t e;
        e.cyc  = cyc_count + n;
        e.val  = v;
        e.name = name;
        q.push_back(e);
    endtask

    initial begin
        edges(1);
        expect_after(0, X_OFF, "reset");
        edges(1);
        rst_n = 1'b1;
        expect_after(1, X_OFF, "idle_off");
        edges(2);

        // Power-up with ack tied to switch enable: E0 is the next edge.
        ack_mode = 1;
        req = 1'b1;
        expect_after(1, X_SW_ON, "pu_sw_on");
        expect_after(2, X_SETTLE, "pu_settle_first");
        expect_after(17, X_SETTLE, "pu_settle_last");
        expect_after(18, X_ISO_REL, "pu_iso_rel_first");
        expect_after(21, X_ISO_REL, "pu_iso_rel_last");
        expect_after(22, X_ON, "pu_on");
        edges(25);

        // Power-down with ack lagging switch enable.
        ack_mode = 2;
        req = 1'b0;
        expect_after(1, X_ISO_SET, "pd_iso_set");
        expect_after(4, X_ISO_SET, "pd_iso_set_last");
        expect_after(5, X_SW_OFF, "pd_sw_off");
        expect_after(7, X_SW_OFF, "pd_ack_wait");
        expect_after(8, X_OFF, "pd_off");
        edges(10);

        // Ack stuck low in SW_ON, then a one-cycle ack glitch during SETTLE.
        ack_mode = 0;
        ack_drv = 1'b0;
        req = 1'b1;
        expect_after(1, X_SW_ON, "stall_sw_on");
        expect_after(50, X_SW_ON, "stall_sw_on_50");
        edges(50);
        ack_drv = 1'b1;
        expect_after(1, X_SETTLE, "stall_settle");
        expect_after(20, X_ISO_REL, "stall_iso_rel_last");
        expect_after(21, X_ON, "stall_on_20");
        edges(3);
        ack_drv = 1'b0;
        edges(1);
        ack_drv = 1'b1;
        edges(17);

        ack_mode = 1;
        req = 1'b0;
        expect_after(5, X_SW_OFF, "pd2_sw_off");
        expect_after(6, X_OFF, "pd2_off");
        edges(6);

        // Request dropped in the 5th SETTLE cycle: power-up still completes.
        req = 1'b1;
        expect_after(22, X_ON, "drop_on");
        expect_after(23, X_ISO_SET, "drop_iso_set");
        expect_after(28, X_OFF, "drop_off");
        edges(6);
        req = 1'b0;
        edges(22);

        // Request toggling while stuck in SW_OFF.
        req = 1'b1;
        expect_after(22, X_ON, "tog_on");
        edges(25);
        ack_mode = 0;
        ack_drv = 1'b1;
        req = 1'b0;
        expect_after(5, X_SW_OFF, "tog_sw_off");
        edges(5);
        req = 1'b1;
        edges(1);
        req = 1'b0;
        edges(1);
        req = 1'b1;
        edges(1);
        expect_after(0, X_SW_OFF, "tog_sw_off_hold");
        ack_drv = 1'b0;
        expect_after(1, X_OFF, "tog_off");
        expect_after(2, X_SW_ON, "tog_sw_on");
        edges(2);

        // Reset mid-sequence while in ISO_REL.
        ack_drv = 1'b1;
        expect_after(18, X_ISO_REL, "rst_in_iso_rel");
        edges(18);
        rst_n = 1'b0;
        expect_after(1, X_OFF, "rst_mid_seq");
        edges(1);
        rst_n = 1'b1;
        expect_after(1, X_SW_ON, "rst_resume");
        edges(3);

        done = 1'b1;
        repeat (3) @(negedge clk);
        if (!reported) begin
            errors++;
            $display("FAIL final_report got none want done");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
